// File: rtl/rr_request_bank_pkg.sv
// Shared definitions for the round-robin requester bank: default sizing,
// derived widths and the grant one-hot check.
package rr_request_bank_pkg;

    localparam int WID_DEF   = 16;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    localparam int WADDR = $clog2(WID_DEF);
    localparam int PTR_W = $clog2(DEPTH_DEF);
    localparam int CNT_W = PTR_W + 1;

    // Grant vectors up to 64 clients are zero-extended into this check.
    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/rr_request_bank_fifo.sv
// Single-client synchronous FIFO: DEPTH x DW storage with registered count,
// full/empty flags and a combinational head word.
module req_client_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DW-1:0]    wdata,
    input  logic             pop,
    output logic [DW-1:0]    rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rr_request_bank.sv
// Requester side of the round-robin interface: per-client FIFOs raise
// requests, legal grants pop one word onto a tagged output stream.
module rr_request_bank
    import rr_request_bank_pkg::*;
#(
    parameter  int WID   = WID_DEF,
    parameter  int DW    = DW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int ID_W  = $clog2(WID),
    localparam int CNT_L = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WID-1:0]    push_valid,
    input  logic [WID*DW-1:0] push_data,
    output logic [WID-1:0]    push_ready,
    output logic [WID-1:0]    requests,
    input  logic [WID-1:0]    grants,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    output logic [DW-1:0]     out_data,
    output logic              err
);

    logic [DW-1:0]    head [WID];
    logic [CNT_L-1:0] cnt  [WID];
    logic [WID-1:0]   full;
    logic [WID-1:0]   empty;
    logic [WID-1:0]   pop_vec;

    logic             grant_legal;
    logic [ID_W-1:0]  grant_idx;

    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             err_q, err_d;

    for (genvar g = 0; g < WID; g++) begin : g_client
        req_client_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_valid[g]),
            .wdata (push_data[g*DW +: DW]),
            .pop   (pop_vec[g]),
            .rdata (head[g]),
            .count (cnt[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
        assign requests[g] = (cnt[g] != '0);
    end

    assign push_ready = ~full;

    // Only a one-hot grant to a non-empty client may pop; anything else is a
    // protocol violation and leaves every FIFO untouched.
    always_comb begin
        grant_legal = is_onehot(64'(grants)) && ((grants & ~empty) != '0);
        pop_vec     = grant_legal ? grants : '0;
        grant_idx   = '0;
        for (int i = 0; i < WID; i++) begin
            if (grants[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = grant_legal;
        out_id_d    = grant_legal ? grant_idx : out_id_q;
        out_data_d  = grant_legal ? head[grant_idx] : out_data_q;
        err_d       = err_q | ((grants != '0) && !grant_legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rr_request_bank.sv
// Self-checking bench for rr_request_bank (WID=4, DW=8, DEPTH=4): directed
// scenarios plus random traffic against a queue-based reference model.
module tb_rr_request_bank;

    localparam int WID   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic [WID-1:0]    push_valid;
    logic [WID*DW-1:0] push_data;
    logic [WID-1:0]    push_ready;
    logic [WID-1:0]    requests;
    logic [WID-1:0]    grants;
    logic              out_valid;
    logic [1:0]        out_id;
    logic [DW-1:0]     out_data;
    logic              err;

    rr_request_bank #(
        .WID   (WID),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .requests   (requests),
        .grants     (grants),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_data   (out_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq [WID][$];
    logic       m_valid;
    logic [1:0] m_id;
    logic [7:0] m_data;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WID; i++) mq[i].delete();
        m_valid = 1'b0;
        m_id    = 2'd0;
        m_data  = 8'd0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the reference: decide the grant on pre-edge sizes,
    // then admit pushes only to clients that were not full before the edge.
    task automatic model_edge(input logic [3:0] pv, input logic [31:0] pd, input logic [3:0] g);
        int pre [WID];
        for (int i = 0; i < WID; i++) pre[i] = mq[i].size();
        m_valid = 1'b0;
        if (g != 4'd0) begin
            if ($countones(g) == 1) begin
                int k = 0;
                for (int i = 0; i < WID; i++) if (g[i]) k = i;
                if (pre[k] != 0) begin
                    m_valid = 1'b1;
                    m_id    = 2'(k);
                    m_data  = mq[k].pop_front();
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        for (int i = 0; i < WID; i++) begin
            if (pv[i] && pre[i] != DEPTH) mq[i].push_back(pd[i*8 +: 8]);
        end
    endtask

    task automatic check_all();
        logic [3:0] e_req, e_rdy;
        for (int i = 0; i < WID; i++) begin
            e_req[i] = (mq[i].size() != 0);
            e_rdy[i] = (mq[i].size() != DEPTH);
        end
        check("requests", 32'(requests), 32'(e_req));
        check("push_ready", 32'(push_ready), 32'(e_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_id", 32'(out_id), 32'(m_id));
        check("out_data", 32'(out_data), 32'(m_data));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic step(input logic [3:0] pv, input logic [31:0] pd, input logic [3:0] g);
        push_valid = pv;
        push_data  = pd;
        grants     = g;
        @(posedge clk);
        model_edge(pv, pd, g);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'd0, 4'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        push_valid = '0;
        push_data  = '0;
        grants     = '0;
        rst_n      = 1'b0;
        #3;
        model_clear();
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] word_at(input int c, input logic [7:0] d);
        logic [31:0] w;
        w = 32'd0;
        w[c*8 +: 8] = d;
        return w;
    endfunction

    initial begin
        push_valid = '0;
        push_data  = '0;
        grants     = '0;
        rst_n      = 1'b0;
        model_clear();
        #12;
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Single word on client 2.
        step(4'b0100, word_at(2, 8'hA1), 4'b0000);
        check("t2_req", 32'(requests), 32'h4);
        idle(1);
        step(4'b0000, 32'd0, 4'b0100);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_id", 32'(out_id), 32'd2);
        check("t2_data", 32'(out_data), 32'hA1);
        idle(1);
        check("t2_req_drop", 32'(requests), 32'd0);

        // Fill client 0, overflow attempt, then drain in order.
        for (int i = 0; i < 4; i++) step(4'b0001, word_at(0, 8'(8'h10 + i)), 4'b0000);
        check("t3_full", 32'(push_ready[0]), 32'd0);
        step(4'b0001, word_at(0, 8'h14), 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 32'd0, 4'b0001);
            check("t3_order", 32'(out_data), 32'(8'h10 + i));
        end
        check("t3_ready", 32'(push_ready[0]), 32'd1);
        check("t3_err", 32'(err), 32'd0);

        // Simultaneous push and pop on client 1.
        step(4'b0010, word_at(1, 8'h21), 4'b0000);
        step(4'b0010, word_at(1, 8'h22), 4'b0000);
        step(4'b0010, word_at(1, 8'h55), 4'b0010);
        check("t4_head", 32'(out_data), 32'h21);
        step(4'b0000, 32'd0, 4'b0010);
        step(4'b0000, 32'd0, 4'b0010);
        check("t4_last", 32'(out_data), 32'h55);

        // Multi-bit grant with two non-empty clients.
        step(4'b0011, word_at(0, 8'h30) | word_at(1, 8'h31), 4'b0000);
        step(4'b0000, 32'd0, 4'b0011);
        check("t5_novalid", 32'(out_valid), 32'd0);
        check("t5_err", 32'(err), 32'd1);
        idle(2);
        check("t5_sticky", 32'(err), 32'd1);

        // Grant to an empty client straight after reset.
        pulse_reset();
        step(4'b0000, 32'd0, 4'b1000);
        check("t6_err", 32'(err), 32'd1);

        // Reset with every client loaded.
        pulse_reset();
        step(4'b1111, 32'hD3C2B1A0, 4'b0000);
        check("t7_loaded", 32'(requests), 32'hF);
        pulse_reset();
        check("t7_req", 32'(requests), 32'd0);

        // Random traffic, periodically reset so err is exercised both ways.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] pv, g;
            int r;
            if (n % 160 == 159) pulse_reset();
            pv = 4'($urandom_range(0, 15));
            r  = $urandom_range(0, 99);
            g  = 4'd0;
            if (r < 65) begin
                int k = $urandom_range(0, WID - 1);
                if (mq[k].size() != 0 || r < 3) g[k] = 1'b1;
            end else if (r >= 97) begin
                g = 4'($urandom_range(1, 15));
            end
            step(pv, $urandom, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
